uart_rx_cfg: RTL

Parametrised UART receiver, successor to the fixed 8N1 `uart_rx`. It decodes a serial `rx` line using the oversampling strobe from `baud_tick_gen`. Data width, oversampling ratio, parity and stop-bit count are configurable, and framing and parity errors are reported alongside each received word. It sits between the pad-side `rx` input and the command/FIFO logic that consumes `rx_data`/`rx_done`.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sampler.sv | 48 ++++
 rtl/uart_rx_cfg.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: state encoding,
// parameter defaults and the legal DATA_BITS range.
package uart_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2
    } rxState_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for uart_rx_cfg: 2-FF synchronizer, falling-edge detect and,
// with UART_RX_MAJORITY_EN defined, a 2-of-3 majority voter over the last three ticks.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
`ifdef UART_RX_MAJORITY_EN
    input  logic tick,
`endif
    input  logic rx,
    output logic rx_s,
    output logic fall,
    output logic bit_val
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Reset to 0 so a line already low at release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx};
            prev_q <= sync_q[1];
        end
    end

    assign rx_s = sync_q[1];
    assign fall = prev_q & ~sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= 2'b00;
        end else if (tick) begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, optional parity, 1 or 2 stop bits).
// Define UART_RX_MAJORITY_EN to take every bit decision by 2-of-3 majority vote.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] MID_T  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_B = BW'(DATA_BITS - 1);

    logic rxS, fall, bitVal;

    rxState_e             state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parEn_q, parEn_d, parOdd_q, parOdd_d, stop2_q, stop2_d;
    logic                 ferrPend_q, ferrPend_d, perrPend_q, perrPend_d;
    logic [DATA_BITS-1:0] rxData_q, rxData_d;
    logic                 rxDone_q, rxDone_d, frameErr_q, frameErr_d, parityErr_q, parityErr_d;
    logic                 atSample, finish;

    uart_rx_sampler u_sampler (
        .clk     (clk),
        .rst     (rst),
`ifdef UART_RX_MAJORITY_EN
        .tick    (tick),
`endif
        .rx      (rx),
        .rx_s    (rxS),
        .fall    (fall),
        .bit_val (bitVal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            parEn_q     <= 1'b0;
            parOdd_q    <= 1'b0;
            stop2_q     <= 1'b0;
            ferrPend_q  <= 1'b0;
            perrPend_q  <= 1'b0;
            rxData_q    <= '0;
            rxDone_q    <= 1'b0;
            frameErr_q  <= 1'b0;
            parityErr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            parEn_q     <= parEn_d;
            parOdd_q    <= parOdd_d;
            stop2_q     <= stop2_d;
            ferrPend_q  <= ferrPend_d;
            perrPend_q  <= perrPend_d;
            rxData_q    <= rxData_d;
            rxDone_q    <= rxDone_d;
            frameErr_q  <= frameErr_d;
            parityErr_q <= parityErr_d;
        end
    end

    // The start bit is checked at half a bit, every later bit one full bit after the previous.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        parEn_d     = parEn_q;
        parOdd_d    = parOdd_q;
        stop2_d     = stop2_q;
        ferrPend_d  = ferrPend_q;
        perrPend_d  = perrPend_q;
        rxData_d    = rxData_q;
        rxDone_d    = 1'b0;
        frameErr_d  = frameErr_q;
        parityErr_d = parityErr_q;
        finish      = 1'b0;
        atSample    = tick && (tcnt_q == ((state_q == START) ? MID_T : LAST_T));

        if (state_q != IDLE && tick) begin
            tcnt_d = atSample ? '0 : tcnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (fall && !rxS) begin
                    state_d    = START;
                    tcnt_d     = '0;
                    bitcnt_d   = '0;
                    parEn_d    = parity_en;
                    parOdd_d   = parity_odd;
                    stop2_d    = stop2;
                    ferrPend_d = 1'b0;
                    perrPend_d = 1'b0;
                end
            end
            START: begin
                if (atSample) begin
                    state_d = bitVal ? IDLE : DATA;
                end
            end
            DATA: begin
                if (atSample) begin
                    shift_d = {bitVal, shift_q[DATA_BITS-1:1]};
                    if (bitcnt_q == LAST_B) begin
                        state_d = parEn_q ? PARITY : STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (atSample) begin
                    perrPend_d = (^shift_q) ^ bitVal ^ parOdd_q;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (atSample) begin
                    ferrPend_d = ferrPend_q | ~bitVal;
                    state_d    = stop2_q ? STOP2 : IDLE;
                    finish     = !stop2_q;
                end
            end
            STOP2: begin
                if (atSample) begin
                    ferrPend_d = ferrPend_q | ~bitVal;
                    state_d    = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            rxData_d    = shift_q;
            rxDone_d    = 1'b1;
            frameErr_d  = ferrPend_q | ~bitVal;
            parityErr_d = perrPend_q;
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    assign rx_data    = rxData_q;
    assign rx_done    = rxDone_q;
    assign frame_err  = frameErr_q;
    assign parity_err = parityErr_q;

endmodule
